// File: rtl/fifo_wr_arbiter_if.sv
// Enqueue-side bundle between NREQ producers, the write arbiter and a FIFO.
// FIFO_ARB_TAG_EN widens fifo_wdata by IDW bits for the source tag.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int N    = 32
);
  localparam int IDW = $clog2(NREQ);
`ifdef FIFO_ARB_TAG_EN
  localparam int WW = N + IDW;
`else
  localparam int WW = N;
`endif

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_we;
  logic [WW-1:0]     fifo_wdata;
  logic [IDW-1:0]    grant_id;
  logic              locked;

  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_we, fifo_wdata, grant_id, locked
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_we, fifo_wdata, grant_id, locked
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin FIFO write arbiter with optional burst lock.
// FIFO_ARB_TAG_EN prepends the owner index to fifo_wdata.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] lock_id;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] scan_id;
  logic           found;
  logic [IDW-1:0] owner;
  logic           xfer;
  logic           last_beat;
  logic [N-1:0]   odata;

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] id);
    return (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
  endfunction

  // first valid requester scanning from ptr, wrapping mod NREQ
  always_comb begin
    scan_id = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        found   = 1'b1;
        scan_id = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign owner     = (state == LOCK) ? lock_id : scan_id;
  assign xfer      = !rst && bus.req_valid[owner] && !bus.fifo_full;
  assign last_beat = bus.req_last[lock_id] ||
                     (cnt == CW'(MAX_BURST - 1));
  assign odata     = bus.req_data[int'(owner)*N +: N];

  always_comb begin
    bus.req_ready = '0;
    if (!rst && !bus.fifo_full)
      bus.req_ready[owner] = 1'b1;
  end

  assign bus.fifo_we  = xfer;
  assign bus.grant_id = rst ? '0 : owner;
  assign bus.locked   = (state == LOCK);
`ifdef FIFO_ARB_TAG_EN
  assign bus.fifo_wdata = {owner, odata};
`else
  assign bus.fifo_wdata = odata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      lock_id <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (!bus.req_last[owner] && MAX_BURST > 1) begin
              state   <= LOCK;
              lock_id <= owner;
              cnt     <= CW'(1);
            end else begin
              ptr <= nxt(owner);
            end
          end
        end
        LOCK: begin
          if (xfer) begin
            if (last_beat) begin
              state <= IDLE;
              ptr   <= nxt(lock_id);
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, N=32, MAX_BURST=4).
// Build with FIFO_ARB_TAG_EN to exercise the tagged wdata.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int MB   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] dv [NREQ];
  logic full;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .N(N)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .N(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      bus.req_data[i*N +: N] = dv[i];
  end
  assign bus.fifo_full = full;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input int id, input logic [31:0] d);
    logic [1:0] t;
    t = id[1:0];
`ifdef FIFO_ARB_TAG_EN
    return {30'b0, t, d};
`else
    return {32'b0, d};
`endif
  endfunction

  // inputs are already set; check outputs, then advance one clock
  task automatic beat(input string tag, input int id,
                      input logic we, input logic lk);
    logic [3:0] rdy;
    #1;
    rdy = full ? 4'b0 : 4'(1 << id);
    chk({tag, ".gid"}, 64'(bus.grant_id), 64'(id));
    chk({tag, ".we"}, 64'(bus.fifo_we), 64'(we));
    chk({tag, ".lock"}, 64'(bus.locked), 64'(lk));
    chk({tag, ".rdy"}, 64'(bus.req_ready), 64'(rdy));
    if (we)
      chk({tag, ".wd"}, 64'(bus.fifo_wdata), wd(id, dv[id]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    full = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < NREQ; i++)
      dv[i] = 32'hC0DE_0000 | 32'(i);
    #2;
    chk("rst.we", 64'(bus.fifo_we), 64'd0);
    chk("rst.rdy", 64'(bus.req_ready), 64'd0);
    chk("rst.gid", 64'(bus.grant_id), 64'd0);
    chk("rst.lock", 64'(bus.locked), 64'd0);
    @(posedge clk);
    #1;
    chk("rst.we2", 64'(bus.fifo_we), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      dv[i % 4] = 32'hA500_0000 | 32'(i);
      beat("rr", i % 4, 1'b1, 1'b0);
    end

    bus.req_valid = 4'b0111;
    beat("pre", 0, 1'b1, 1'b0);
    bus.req_last = 4'b1101;
    dv[1] = 32'hB000_0001;
    beat("b1", 1, 1'b1, 1'b0);
    dv[1] = 32'hB000_0002;
    beat("b2", 1, 1'b1, 1'b1);
    bus.req_last = 4'b1111;
    dv[1] = 32'hB000_0003;
    beat("b3", 1, 1'b1, 1'b1);
    beat("bnext", 2, 1'b1, 1'b0);

    bus.req_valid = 4'b1001;
    bus.req_last  = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      dv[3] = 32'hCA90_0000 | 32'(b);
      beat("cap", 3, 1'b1, b > 0);
    end
    bus.req_last = 4'b0001;
    beat("capnext", 0, 1'b1, 1'b0);

    dv[3] = 32'hBB00_0001;
    beat("bp1", 3, 1'b1, 1'b0);
    full = 1'b1;
    dv[3] = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++)
      beat("bpfull", 3, 1'b0, 1'b1);
    full = 1'b0;
    for (int b = 2; b <= 4; b++) begin
      dv[3] = 32'hBB00_0000 | 32'(b);
      beat("bp", 3, 1'b1, 1'b1);
    end
    beat("bpend", 0, 1'b1, 1'b0);

    bus.req_valid = 4'b0000;
    beat("noreq", 1, 1'b0, 1'b0);

    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0100;
    dv[2] = 32'hDEAD_BEEF;
`ifdef FIFO_ARB_TAG_EN
    #1;
    chk("tag.lit", 64'(bus.fifo_wdata), 64'h2_DEAD_BEEF);
`endif
    beat("tag", 2, 1'b1, 1'b0);

    bus.req_last = 4'b0000;
    beat("mr1", 2, 1'b1, 1'b0);
    #1;
    chk("mr.lock", 64'(bus.locked), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr.lock0", 64'(bus.locked), 64'd0);
    chk("mr.we", 64'(bus.fifo_we), 64'd0);
    chk("mr.rdy", 64'(bus.req_ready), 64'd0);
    chk("mr.gid", 64'(bus.grant_id), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    beat("mrafter", 0, 1'b1, 1'b0);
    beat("mrafter2", 1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one pipeline FIFO enqueue port among NREQ producers.
- Optionally holds a grant across a multi-beat burst.
- Sits directly in front of the FIFO: drives its we/wdata and observes its full flag.
- Dequeue side of the FIFO is untouched.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- N, 32: data width per beat.
- MAX_BURST, 4: max beats per locked grant, >=1. A value of 1 disables locking.
- IDW (localparam), $clog2(NREQ): requester index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  NREQ  per-requester beat valid
- req_last  input  NREQ  per-requester end-of-burst marker, sampled with valid
- req_data  input  NREQ*N  requester i data at [i*N +: N]
- req_ready  output  NREQ  per-requester beat accepted (one-hot or zero)
- fifo_full  input  1  FIFO full flag, already reflecting same-cycle dequeue
- fifo_we  output  1  FIFO enqueue strobe
- fifo_wdata  output  N (N+IDW with tag option)  FIFO enqueue data
- grant_id  output  IDW  current owner index
- locked  output  1  high while in LOCK state

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, ptr=0, cnt=0.
  - fifo_we=0, req_ready=0, locked=0, grant_id=0, forced regardless of inputs.
- Owner selection:
  - IDLE: owner = first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - No request: owner=ptr, fifo_we=0.
  - LOCK: owner = latched lock_id; other requesters are ignored.
- Transfer: xfer = req_valid[owner] && !fifo_full.
  - Combinational, zero latency: fifo_we=xfer, fifo_wdata=req_data[owner], req_ready[owner]=!fifo_full.
  - All other req_ready bits are 0.
  - req_ready never asserts for a requester that is not the owner.
- State machine:
  - IDLE -> LOCK: xfer && !req_last[owner] && MAX_BURST>1. Latch lock_id=owner, set cnt=1. ptr is unchanged.
  - IDLE, single-beat xfer (last=1 or MAX_BURST=1): ptr <= owner+1 mod NREQ. Stay IDLE.
  - LOCK, xfer: cnt <= cnt+1.
  - LOCK -> IDLE: xfer && (req_last[lock_id] || cnt==MAX_BURST-1). Then ptr <= lock_id+1 mod NREQ, cnt <= 0.
  - LOCK, owner valid low or fifo_full high: hold state, cnt and lock_id. There is no timeout.
- Wrap-around: ptr increment wraps NREQ-1 -> 0. cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
- fifo_full=1: no xfer. State, ptr and cnt are frozen. Data need not be stable.
- Simultaneous requests: exactly one owner per cycle. Priority rotates so each continuously-requesting producer is served within NREQ grants.
- grant_id = owner every cycle. locked = (state==LOCK).
- Reset mid-burst: immediately returns to IDLE, ptr=0. The partial burst is abandoned; the producer resends.

Optional Feature:
- Macro FIFO_ARB_TAG_EN.
- Defined:
  - fifo_wdata width is N+IDW.
  - fifo_wdata = {owner, req_data[owner]}, so the source index occupies the MSBs.
  - The downstream FIFO must be instantiated with N+IDW.
- Undefined: fifo_wdata width is N, no tag, and IDW bits are not appended.

Test Plan:
- Reset check: assert rst with req_valid=4'b1111 -> fifo_we=0, req_ready=0, grant_id=0. Deassert rst -> first grant goes to requester 0.
- Round-robin: all four valid, req_last=1, fifo_full=0 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3, one fifo_we per cycle, wdata matches each source.
- Burst lock: req1 sends 3 beats with last on beat 3 while req0/2 stay valid -> locked=1 for beats 2-3, grant_id=1 for 3 cycles. Next grant goes to 2.
- Burst cap: MAX_BURST=4, req3 sends 6 beats with no last -> unlock after beat 4. Next grant goes to 0 if valid, then req3 resumes later.
- Backpressure: fifo_full=1 for 3 cycles mid-burst -> fifo_we=0, req_ready=0, cnt and lock_id held. On release the burst continues with no beat lost or duplicated.
- Tag option (FIFO_ARB_TAG_EN, NREQ=4, N=32): req2 data 32'hDEADBEEF -> fifo_wdata=34'h2_DEADBEEF.
